rr_arbiter4: RTL and testbench



---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_prio_encoder4.sv | 37 +++
 rtl/rr_arbiter4.sv | 111 +++++++++++
 tb/tb_rr_arbiter4.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg : shared types and helpers for the 4-way round-robin arbiter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_prio_encoder4.sv
// ---------------------------------------------------------------------------
// rr_prio_encoder4 : rotating priority encoder, ptr is the highest priority
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_prio_encoder4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  win_id
);

  logic [N_REQ-1:0] rotated;
  logic [ID_W-1:0]  offset;

  always_comb begin
    // Bit i of rotated is requester (ptr + i) mod 4; the 2-bit index wraps.
    rotated = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rotated[i] = req[ID_W'(i) + ptr];
    end
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = ID_W'(i);
      end
    end
    any    = |req;
    win_id = offset + ptr;
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4 : 4-requester round-robin arbiter with bounded grant hold time
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             expired
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(HOLD_LAST);
  localparam logic [CNT_W-1:0] HOLD_MAX_C  = CNT_W'(MAX_HOLD);

  arb_state_t       state, state_next;
  logic [ID_W-1:0]  ptr, ptr_next;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
  logic [N_REQ-1:0] gnt_next;
  logic [ID_W-1:0]  gnt_id_next;
  logic             expired_next;

  logic             any;
  logic [ID_W-1:0]  win_id;
  logic             rel_normal;
  logic             rel_timeout;

  rr_prio_encoder4 u_prio (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .win_id (win_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      hold_cnt  <= hold_cnt_next;
      gnt       <= gnt_next;
      gnt_id    <= gnt_id_next;
      gnt_valid <= |gnt_next;
      expired   <= expired_next;
    end
  end

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    hold_cnt_next = hold_cnt;
    gnt_next      = gnt;
    gnt_id_next   = gnt_id;
    expired_next  = 1'b0;

    // hold_cnt == MAX_HOLD-1 means this is the MAX_HOLD-th cycle of the grant.
    rel_normal  = done[gnt_id] | ~req[gnt_id];
    rel_timeout = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST_C);

    case (state)
      IDLE: begin
        gnt_next    = '0;
        gnt_id_next = '0;
        if (any) begin
          state_next    = GRANT;
          gnt_next      = onehot(win_id);
          gnt_id_next   = win_id;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        if (rel_normal || rel_timeout) begin
          state_next    = IDLE;
          gnt_next      = '0;
          gnt_id_next   = '0;
          hold_cnt_next = '0;
          ptr_next      = gnt_id + ID_W'(1);
          expired_next  = rel_timeout & ~rel_normal;
        end else if (hold_cnt != HOLD_MAX_C) begin
          hold_cnt_next = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next  = IDLE;
        gnt_next    = '0;
        gnt_id_next = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4 : scoreboard bench with a cycle-level reference model
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       expired;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: current owner (-1 = none), cycles held so far, first in line.
  int m_owner = -1;
  int m_age   = 0;
  int m_first = 0;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    exp_t e;
    logic ex;
    bit   normal, timeout;
    @(negedge clk);
    reset = rs;
    req   = r;
    done  = d;
    ex    = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_age   = 0;
      m_first = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_first + k) % 4]) begin
          m_owner = (m_first + k) % 4;
          m_age   = 1;
        end
      end
    end else begin
      normal  = d[m_owner] || !r[m_owner];
      timeout = (MAX_HOLD != 0) && (m_age == MAX_HOLD);
      if (normal || timeout) begin
        m_first = (m_owner + 1) % 4;
        ex      = timeout && !normal;
        m_owner = -1;
        m_age   = 0;
      end else begin
        m_age++;
      end
    end
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.valid = (m_owner >= 0);
    e.exp   = ex;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== e.gnt || gnt_id !== e.id || gnt_valid !== e.valid || expired !== e.exp) begin
        n_fail++;
        $display("FAIL cycle_out t=%0t: got gnt=%b id=%0d valid=%b exp=%b, want gnt=%b id=%0d valid=%b exp=%b",
                 $time, gnt, gnt_id, gnt_valid, expired, e.gnt, e.id, e.valid, e.exp);
      end
    end
  end

  // Pulses done for whoever the reference says holds the grant.
  function automatic logic [3:0] done_for_owner();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  initial begin
    reset = 1'b1;
    req   = '0;
    done  = '0;

    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);

    // Basic grant, release, then ptr skips the idle requester 1.
    step(4'b0101, 4'b0000, 1'b0);
    step(4'b0101, 4'b0001, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Fairness with all requesting.
    step(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 12; i++) step(4'b1111, done_for_owner(), 1'b0);

    // Timeout with a lone requester.
    step(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 22; i++) step(4'b1000, 4'b0000, 1'b0);

    // done coinciding with the timeout cycle.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b1000, 4'b0000, 1'b0);
    for (int i = 0; i < 7; i++) step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b1000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Requester 3 drops; non-owner done ignored; ptr wraps to 0.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1011, 4'b0010, 1'b0);
    step(4'b0011, 4'b0000, 1'b0);
    step(4'b0011, 4'b0000, 1'b0);
    step(4'b0011, 4'b0000, 1'b0);

    // Reset in the middle of a grant.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0000, 1'b0);
    step(4'b0011, 4'b0000, 1'b0);

    // Random traffic, occasional reset, sparse done pulses.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r, d;
      logic       rs;
      r  = 4'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 5) == 0) r = 4'b1111;
      rs = ($urandom_range(0, 199) == 0);
      step(r, d, rs);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
